// File: rtl/scan_decoder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : scan_decoder_pkg                                            |
// | Brief   : States, mode encodings and one-hot helper for scan_decoder  |
// | Rev     : 1.0                                                         |
// +-----------------------------------------------------------------------+
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest decode supported (SEL_W up to 8); callers size-cast the result.
    localparam int ONEHOT_MAX_W = 256;

    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [7:0] idx,
                                                       input logic [8:0] width);
        logic [ONEHOT_MAX_W-1:0] result;
        result = '0;
        if ({1'b0, idx} < width) begin
            result[idx] = 1'b1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_decoder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : scan_decoder_if                                             |
// | Brief   : Control and decoded-output bundle for scan_decoder          |
// | Rev     : 1.0                                                         |
// +-----------------------------------------------------------------------+
interface scan_decoder_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 2**SEL_W;

    logic             en;
    logic             mode;
    logic             sel_valid;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] scan_last;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (
        output en, mode, sel_valid, sel, scan_last,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, sel_valid, sel, scan_last,
        output out, idx, wrap
    );

endinterface
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : dwell_timer                                                 |
// | Brief   : Counts DWELL cycles while run is high; tick on last cycle   |
// | Rev     : 1.0                                                         |
// +-----------------------------------------------------------------------+
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int DWELL_W = $clog2(DWELL + 1);
    localparam logic [DWELL_W-1:0] c_dwell_last = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] r_cnt;

    assign tick = run && (r_cnt == c_dwell_last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (run) begin
            if (r_cnt == c_dwell_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : scan_decoder                                                |
// | Brief   : Registered index-to-one-hot decoder, DIRECT and SCAN modes  |
// | Option  : SCAN_DECODER_BLANK_EN inserts a blank cycle between indices |
// | Rev     : 1.0                                                         |
// +-----------------------------------------------------------------------+
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst,
    scan_decoder_if.slave  bus
);

    localparam int OUT_W = 2**SEL_W;

    state_t           r_state;
    state_t           w_next;
    logic [OUT_W-1:0] r_out;
    logic [OUT_W-1:0] w_out;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] w_idx;
    logic             r_wrap;
    logic             w_wrap;
    logic             r_started;
    logic             w_started;
    logic             r_blank;
    logic             w_blank;

    logic             w_hold_scan;
    logic             w_run;
    logic             w_tick;
    logic             w_at_last;
    logic [SEL_W-1:0] w_idx_succ;
    logic [OUT_W-1:0] w_oh_sel;
    logic [OUT_W-1:0] w_oh_cur;

    assign w_oh_sel   = OUT_W'(onehot(8'(bus.sel), 9'(OUT_W)));
    assign w_oh_cur   = OUT_W'(onehot(8'(r_idx), 9'(OUT_W)));
    assign w_at_last  = (r_idx >= bus.scan_last);
    assign w_idx_succ = w_at_last ? '0 : r_idx + 1'b1;

`ifndef SCAN_DECODER_BLANK_EN
    logic [OUT_W-1:0] w_oh_succ;
    assign w_oh_succ = OUT_W'(onehot(8'(w_idx_succ), 9'(OUT_W)));
`endif

    // Dwell counting only runs while an index is actually being shown.
    assign w_hold_scan = (r_state == ST_SCAN) && (w_next == ST_SCAN);
    assign w_run       = w_hold_scan && r_started && !r_blank;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (!w_run),
        .run  (w_run),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_out     <= '0;
            r_idx     <= '0;
            r_wrap    <= 1'b0;
            r_started <= 1'b0;
            r_blank   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_out     <= w_out;
            r_idx     <= w_idx;
            r_wrap    <= w_wrap;
            r_started <= w_started;
            r_blank   <= w_blank;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!bus.en) begin
            w_next = ST_IDLE;
        end else if (bus.mode == MODE_SCAN) begin
            w_next = ST_SCAN;
        end else begin
            w_next = ST_DIRECT;
        end
    end

    // Any state change, and IDLE itself, restarts from a blank output.
    always_comb begin
        w_out     = '0;
        w_idx     = '0;
        w_wrap    = 1'b0;
        w_started = 1'b0;
        w_blank   = 1'b0;
        if (r_state == w_next) begin
            case (r_state)
                ST_DIRECT: begin
                    w_out = r_out;
                    w_idx = r_idx;
                    if (bus.sel_valid) begin
                        w_out = w_oh_sel;
                        w_idx = bus.sel;
                    end
                end
                ST_SCAN: begin
                    w_started = 1'b1;
                    if (!r_started) begin
                        w_out = OUT_W'(1);
                        w_idx = '0;
                    end else if (r_blank) begin
                        w_out  = w_oh_cur;
                        w_idx  = r_idx;
                        w_wrap = (r_idx == '0);
                    end else if (w_tick) begin
`ifdef SCAN_DECODER_BLANK_EN
                        w_out   = '0;
                        w_idx   = w_idx_succ;
                        w_blank = 1'b1;
`else
                        w_out  = w_oh_succ;
                        w_idx  = w_idx_succ;
                        w_wrap = w_at_last;
`endif
                    end else begin
                        w_out = r_out;
                        w_idx = r_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out  = r_out;
    assign bus.idx  = r_idx;
    assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised successor to the team's fixed 3-to-8 decoder. Converts an SEL_W-bit index into a registered 2**SEL_W one-hot output.
- Two run-time modes:
  - DIRECT: latches an index on a valid strobe.
  - SCAN: steps the one-hot output through indices 0..scan_last, holding each for DWELL cycles.
- Intended for display digit/row scanning and chip-select generation.

Parameters:
- SEL_W, 3, index width; output width OUT_W = 2**SEL_W (localparam, not overridable).
- DWELL, 4, clock cycles each index is held in SCAN mode; legal range 1..65535.
- DWELL_W is a localparam equal to $clog2(DWELL+1), the width of the dwell counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; when 0 the block goes to IDLE.
- mode  in  1  0 = DIRECT, 1 = SCAN.
- sel_valid  in  1  DIRECT-mode strobe; captures sel.
- sel  in  SEL_W  DIRECT-mode index.
- scan_last  in  SEL_W  highest index visited in SCAN; sampled every cycle.
- out  out  OUT_W  registered one-hot output (all zero when blank/idle).
- idx  out  SEL_W  registered index currently driven on out.
- wrap  out  1  one-cycle pulse when the scan returns to index 0.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, out=0, idx=0, wrap=0, dwell counter=0. Reset has priority over all other inputs.
- All outputs are registered.
- IDLE:
  - out=0, idx=0.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> SCAN.
  - Transition takes one cycle; out stays 0 on the transition cycle.
- DIRECT:
  - out=0 until the first sel_valid.
  - sel_valid=1 at edge N -> idx=sel and out=1<<sel from edge N+1 (latency 1).
  - out holds until the next sel_valid.
  - Back-to-back sel_valid updates every cycle.
- SCAN:
  - On entry: idx=0, out=1<<0, counter=0.
  - Counter increments each cycle.
  - When counter==DWELL-1, the counter clears and the index advances:
    - if idx>=scan_last: idx=0 and wrap=1 for exactly the cycle where out=1<<0 is first driven;
    - otherwise idx=idx+1.
  - DWELL=1 -> index advances every cycle.
  - sel_valid is ignored.
- Mode/enable change mid-operation:
  - en=0 -> IDLE on the next edge.
  - mode toggle -> the new mode is entered on the next edge with a fresh start (DIRECT: out=0; SCAN: idx=0, counter=0).
  - No wrap pulse on the initial SCAN entry.
- scan_last=0 -> out stays at 1<<0 and wrap pulses every DWELL cycles.
- scan_last lowered below the current idx -> wraps to 0 at the end of the current dwell.
- scan_last = 2**SEL_W-1 -> full-range scan; idx never overflows.
- wrap is 0 outside SCAN.
- Invariant: out is always either zero or exactly one-hot, and when one-hot it equals 1<<idx.

Optional Feature:
- Macro SCAN_DECODER_BLANK_EN.
- Defined:
  - In SCAN, after every dwell period out=0 for one cycle (anti-ghosting gap) before the next index is driven.
  - Period per index = DWELL+1.
  - idx already shows the next index during the blank cycle.
  - wrap coincides with the first non-blank cycle of index 0.
  - DIRECT mode is unaffected.
- Undefined: no blank cycles; period per index = DWELL.

Decomposition:
- Package scan_decoder_pkg:
  - state enum {ST_IDLE, ST_DIRECT, ST_SCAN};
  - mode constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1;
  - function onehot(idx, width).
- One sub-module, dwell_timer:
  - parametrised by DWELL;
  - inputs clk, rst, clr, run;
  - output tick (high on the last dwell cycle).
  - The FSM, index register and output register stay in scan_decoder.

Test Plan (SEL_W=3, DWELL=2 unless stated):
- Reset: rst held 3 cycles with en=1, mode=1 -> out=0x00, idx=0, wrap=0 during and one cycle after release; the cycle after that, out=0x01.
- DIRECT: sel_valid pulses with sel=5 then sel=2 on consecutive cycles -> out=0x20 then 0x04 on the following edges; holds 0x04 with sel_valid=0.
- SCAN full range: scan_last=7 -> out sequence 01,01,02,02,...,80,80,01; wrap=1 only on the first 0x01 after 0x80; wrap period 16 cycles.
- SCAN short/changed limit: scan_last=2, then lowered to 0 while idx=2 -> after the current dwell idx=0 with wrap; thereafter out fixed at 0x01 with wrap every 2 cycles.
- Mode switch mid-scan: at idx=4 drop mode to 0 -> next cycle out=0x00; sel_valid with sel=7 -> out=0x80. Then en=0 -> out=0x00, idx=0.
- SCAN_DECODER_BLANK_EN defined, DWELL=1, scan_last=1 -> out sequence 01,00,02,00,01; period 4 cycles; wrap aligned with 0x01.
